// File: rtl/param_counter.sv
// Parameterised up/down counter with enable prescaler, wrap or saturate at the
// boundaries, one-cycle terminal-count pulse and a sticky boundary flag.
module param_counter #(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_VAL  = '1,
   parameter int unsigned      PRESCALE = 1,
   parameter bit               SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             ovf
);

   localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   // Elaboration-time parameter range checks
   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("param_counter: WIDTH out of range 2..32");
   end
   if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
      $error("param_counter: PRESCALE out of range 1..256");
   end
   if (MAX_VAL == '0) begin : g_bad_max
      $error("param_counter: MAX_VAL must be at least 1");
   end

   logic [WIDTH-1:0] r_out;
   logic [PW-1:0]    r_pre;
   logic             r_tc;
   logic             r_ovf;

   logic [WIDTH-1:0] w_out_nxt;
   logic [PW-1:0]    w_pre_nxt;
   logic             w_tc_nxt;
   logic             w_ovf_nxt;
   logic             w_step;
   logic             w_at_bound;

   assign w_step     = enable && (r_pre == PRE_LAST);
   assign w_at_bound = up_dn ? (r_out == MAX_VAL) : (r_out == '0);

   // Next-state: clear, then load, then prescaled step
   always_comb begin
      w_out_nxt = r_out;
      w_pre_nxt = r_pre;
      w_tc_nxt  = 1'b0;
      w_ovf_nxt = r_ovf;
      if (clear) begin
         w_out_nxt = '0;
         w_pre_nxt = '0;
         w_ovf_nxt = 1'b0;
      end else if (load) begin
         w_out_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
         w_pre_nxt = '0;
      end else if (w_step) begin
         w_pre_nxt = '0;
         if (w_at_bound) begin
            w_tc_nxt  = 1'b1;
            w_ovf_nxt = 1'b1;
            if (!SATURATE) begin
               w_out_nxt = up_dn ? '0 : MAX_VAL;
            end
         end else begin
            w_out_nxt = up_dn ? (r_out + WIDTH'(1)) : (r_out - WIDTH'(1));
         end
      end else if (enable) begin
         w_pre_nxt = r_pre + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out <= '0;
         r_pre <= '0;
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         r_out <= w_out_nxt;
         r_pre <= w_pre_nxt;
         r_tc  <= w_tc_nxt;
         r_ovf <= w_ovf_nxt;
      end
   end

   assign out = r_out;
   assign tc  = r_tc;
   assign ovf = r_ovf;

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: four instances (wrap, prescale, clipped max, saturate)
// driven from a vector table and hand sequences, checked through a scoreboard queue.
module tb_param_counter;

   typedef struct {
      int         inst;
      logic [7:0] out;
      logic       tc;
      logic       ovf;
      string      name;
   } exp_t;

   typedef struct {
      int         inst;
      bit         r, e, u, c, l;
      logic [7:0] v;
      logic [7:0] eo;
      bit         et, eov;
      string      name;
   } vec_t;

   logic            clk = 1'b0;
   logic [3:0]      rst_v, en_v, ud_v, clr_v, ld_v;
   logic [3:0][7:0] lv_v;
   logic [3:0][7:0] out_v;
   logic [3:0]      tc_v, ovf_v;

   exp_t sb[$];
   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   param_counter #(.WIDTH(8), .MAX_VAL(8'd255), .PRESCALE(1), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .reset(rst_v[0]), .enable(en_v[0]), .up_dn(ud_v[0]), .clear(clr_v[0]),
      .load(ld_v[0]), .load_val(lv_v[0]), .out(out_v[0]), .tc(tc_v[0]), .ovf(ovf_v[0]));

   param_counter #(.WIDTH(8), .MAX_VAL(8'd255), .PRESCALE(4), .SATURATE(1'b0)) u_pre (
      .clk(clk), .reset(rst_v[1]), .enable(en_v[1]), .up_dn(ud_v[1]), .clear(clr_v[1]),
      .load(ld_v[1]), .load_val(lv_v[1]), .out(out_v[1]), .tc(tc_v[1]), .ovf(ovf_v[1]));

   param_counter #(.WIDTH(8), .MAX_VAL(8'd150), .PRESCALE(1), .SATURATE(1'b0)) u_max (
      .clk(clk), .reset(rst_v[2]), .enable(en_v[2]), .up_dn(ud_v[2]), .clear(clr_v[2]),
      .load(ld_v[2]), .load_val(lv_v[2]), .out(out_v[2]), .tc(tc_v[2]), .ovf(ovf_v[2]));

   param_counter #(.WIDTH(8), .MAX_VAL(8'd255), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(rst_v[3]), .enable(en_v[3]), .up_dn(ud_v[3]), .clear(clr_v[3]),
      .load(ld_v[3]), .load_val(lv_v[3]), .out(out_v[3]), .tc(tc_v[3]), .ovf(ovf_v[3]));

   task automatic idle_all();
      rst_v = '1; en_v = '0; ud_v = '1; clr_v = '0; ld_v = '0; lv_v = '0;
   endtask

   task automatic set_in(input int k, input bit r, input bit e, input bit u,
                         input bit c, input bit l, input logic [7:0] v);
      rst_v[k] = r; en_v[k] = e; ud_v[k] = u; clr_v[k] = c; ld_v[k] = l; lv_v[k] = v;
   endtask

   task automatic expect_val(input int k, input logic [7:0] o, input bit t, input bit ov,
                             input string nm);
      exp_t x;
      x.inst = k; x.out = o; x.tc = t; x.ovf = ov; x.name = nm;
      sb.push_back(x);
   endtask

   // Advance one clock and retire every pending expectation
   task automatic tick();
      @(posedge clk);
      #1;
      while (sb.size() != 0) begin
         exp_t x;
         x = sb.pop_front();
         checks++;
         if (out_v[x.inst] !== x.out || tc_v[x.inst] !== x.tc || ovf_v[x.inst] !== x.ovf) begin
            failures++;
            $display("FAIL %s inst=%0d: got out=%0d tc=%b ovf=%b, expected out=%0d tc=%b ovf=%b",
                     x.name, x.inst, out_v[x.inst], tc_v[x.inst], ovf_v[x.inst],
                     x.out, x.tc, x.ovf);
         end
      end
   endtask

   function automatic void add(input int k, input bit r, input bit e, input bit u,
                               input bit c, input bit l, input logic [7:0] v,
                               input logic [7:0] eo, input bit et, input bit eov,
                               input string nm);
      vec_t x;
      x.inst = k; x.r = r; x.e = e; x.u = u; x.c = c; x.l = l; x.v = v;
      x.eo = eo; x.et = et; x.eov = eov; x.name = nm;
      tbl.push_back(x);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Prescale=4 instance: step every 4th enabled cycle, holds while disabled
      for (int i = 1; i <= 12; i++) add(1, 1, 1, 1, 0, 0, 8'h00, 8'(i / 4), 0, 0, "pre_run");
      add(1, 1, 1, 1, 0, 0, 8'h00, 8'd3, 0, 0, "pre_to1");
      add(1, 1, 1, 1, 0, 0, 8'h00, 8'd3, 0, 0, "pre_to2");
      add(1, 1, 0, 1, 0, 0, 8'h00, 8'd3, 0, 0, "pre_hold1");
      add(1, 1, 0, 1, 0, 0, 8'h00, 8'd3, 0, 0, "pre_hold2");
      add(1, 1, 1, 1, 0, 0, 8'h00, 8'd3, 0, 0, "pre_resume1");
      add(1, 1, 1, 1, 0, 0, 8'h00, 8'd4, 0, 0, "pre_resume2");
      for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 0, 0, 8'h00, 8'd4, 0, 0, "ud_between_dn");
      add(1, 1, 1, 1, 0, 0, 8'h00, 8'd5, 0, 0, "ud_step_up");
      for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 0, 8'h00, 8'd5, 0, 0, "ud_between_up");
      add(1, 1, 1, 0, 0, 0, 8'h00, 8'd4, 0, 0, "ud_step_dn");
      add(1, 1, 0, 1, 0, 1, 8'h37, 8'h37, 0, 0, "ld_37");
      add(1, 1, 1, 1, 0, 0, 8'h00, 8'h37, 0, 0, "pre_mid1");
      add(1, 1, 1, 1, 0, 0, 8'h00, 8'h37, 0, 0, "pre_mid2");
      add(1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, "mid_reset");
      for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, "post_rst_wait");
      add(1, 1, 1, 1, 0, 0, 8'h00, 8'h01, 0, 0, "post_rst_step");
      // MAX_VAL=150 instance: load clipping, wrap at 150, load/clear priority
      add(2, 1, 0, 1, 0, 1, 8'd200, 8'd150, 0, 0, "ld_clip200");
      add(2, 1, 0, 1, 0, 1, 8'd151, 8'd150, 0, 0, "ld_clip151");
      add(2, 1, 1, 1, 0, 0, 8'd0,   8'd0,   1, 1, "max_wrap_up");
      add(2, 1, 0, 1, 0, 0, 8'd0,   8'd0,   0, 1, "tc_one_cycle");
      add(2, 1, 1, 1, 0, 1, 8'd100, 8'd100, 0, 1, "ld_over_step");
      add(2, 1, 1, 1, 1, 1, 8'd50,  8'd0,   0, 0, "clr_over_ld");
      add(2, 1, 1, 0, 0, 0, 8'd0,   8'd150, 1, 1, "dn_wrap");
      add(2, 1, 1, 0, 0, 0, 8'd0,   8'd149, 0, 1, "dn_step");
      add(2, 1, 1, 1, 1, 0, 8'd0,   8'd0,   0, 0, "clr_over_en");
      add(2, 1, 0, 1, 0, 1, 8'd150, 8'd150, 0, 0, "ld_max");
      // Saturating instance: hold at both boundaries with a pulse per step
      add(3, 1, 0, 1, 0, 1, 8'd2,   8'd2,   0, 0, "sat_ld2");
      add(3, 1, 1, 0, 0, 0, 8'd0,   8'd1,   0, 0, "sat_dn1");
      add(3, 1, 1, 0, 0, 0, 8'd0,   8'd0,   0, 0, "sat_dn2");
      add(3, 1, 1, 0, 0, 0, 8'd0,   8'd0,   1, 1, "sat_dn3");
      add(3, 1, 1, 0, 0, 0, 8'd0,   8'd0,   1, 1, "sat_dn4");
      add(3, 1, 0, 0, 0, 0, 8'd0,   8'd0,   0, 1, "sat_idle");
      add(3, 1, 0, 1, 0, 1, 8'd254, 8'd254, 0, 1, "sat_ld254");
      add(3, 1, 1, 1, 0, 0, 8'd0,   8'd255, 0, 1, "sat_up1");
      add(3, 1, 1, 1, 0, 0, 8'd0,   8'd255, 1, 1, "sat_up2");
      add(3, 1, 0, 1, 0, 0, 8'd0,   8'd255, 0, 1, "sat_idle2");
      add(3, 1, 1, 0, 0, 0, 8'd0,   8'd254, 0, 1, "sat_dn_mid");
      add(3, 1, 0, 1, 1, 0, 8'd0,   8'd0,   0, 0, "sat_clear");

      // Reset held two cycles with enable and load active on every instance
      idle_all();
      rst_v = '0; en_v = '1; ld_v = '1;
      for (int k = 0; k < 4; k++) lv_v[k] = 8'hAA;
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 4; k++) expect_val(k, 8'h00, 0, 0, "reset");
         tick();
      end

      // Full 8-bit wrap sweep from 0 at PRESCALE=1
      for (int k = 1; k <= 256; k++) begin
         idle_all();
         set_in(0, 1, 1, 1, 0, 0, 8'h00);
         expect_val(0, 8'(k % 256), (k == 256), (k == 256), "wrap_sweep");
         tick();
      end
      idle_all();
      expect_val(0, 8'd0, 0, 1, "wrap_tc_end");
      tick();
      idle_all();
      set_in(0, 1, 1, 0, 0, 0, 8'h00);
      expect_val(0, 8'd255, 1, 1, "wrap_dn_from0");
      tick();
      idle_all();
      set_in(0, 1, 1, 1, 0, 0, 8'h00);
      expect_val(0, 8'd0, 1, 1, "wrap_up_from255");
      tick();

      for (int i = 0; i < tbl.size(); i++) begin
         idle_all();
         set_in(tbl[i].inst, tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].c, tbl[i].l, tbl[i].v);
         expect_val(tbl[i].inst, tbl[i].eo, tbl[i].et, tbl[i].eov, tbl[i].name);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal (highest) count value, legal range 1..2**WIDTH-1.
REQ-003 Parameter PRESCALE, default 1: enabled cycles per count step, legal range 1..256.
REQ-004 Parameter SATURATE, default 0: 0 selects wrap at the boundaries, 1 selects hold at the boundaries.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-007 enable  input  1  count enable; advances the prescaler.
REQ-008 up_dn  input  1  direction: 1 = count up, 0 = count down.
REQ-009 clear  input  1  synchronous clear of the count, prescaler and flags.
REQ-010 load  input  1  synchronous load of load_val.
REQ-011 load_val  input  WIDTH  value to load.
REQ-012 out  output  WIDTH  registered count value.
REQ-013 tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 ovf  output  1  registered sticky boundary flag.

Function
REQ-015 Control priority per edge SHALL be: reset, then clear, then load, then step.
REQ-016 Internal prescaler pre_cnt (0..PRESCALE-1) SHALL increment on each edge with enable=1 and hold when enable=0.
REQ-017 A step SHALL occur on an edge where enable=1 and pre_cnt==PRESCALE-1, and pre_cnt SHALL return to 0 on that edge.
REQ-018 With PRESCALE=1, every enabled edge SHALL be a step.
REQ-019 out SHALL change on the step edge itself, so a new value is visible one cycle after the enabling sample.
REQ-020 Up step with out<MAX_VAL SHALL set out to out+1.
REQ-021 Down step with out>0 SHALL set out to out-1.
REQ-022 Up step at out==MAX_VAL SHALL set out to 0 when SATURATE=0, and SHALL hold MAX_VAL when SATURATE=1.
REQ-023 Down step at out==0 SHALL set out to MAX_VAL when SATURATE=0, and SHALL hold 0 when SATURATE=1.
REQ-024 A step taken at a boundary (REQ-022/023) SHALL drive tc=1 for exactly the following cycle and SHALL set ovf=1; every other edge SHALL drive tc=0.
REQ-025 Each boundary step SHALL produce its own tc pulse, so back-to-back saturated steps produce consecutive pulses.
REQ-026 up_dn SHALL be sampled only on step edges; changing it between steps SHALL have no other effect.
REQ-027 load SHALL set out to min(load_val, MAX_VAL), set pre_cnt to 0, drive tc=0, and leave ovf unchanged.
REQ-028 clear SHALL set out, pre_cnt, tc and ovf to 0, regardless of load or enable.
REQ-029 ovf SHALL remain 1 until clear or reset.
REQ-030 A step whose value exceeds MAX_VAL SHALL be impossible; out SHALL never exceed MAX_VAL.

Reset
REQ-031 On an edge with reset=0, out, pre_cnt, tc and ovf SHALL become 0, overriding all other inputs.
REQ-032 After reset deasserts, counting SHALL resume from out=0 with a full PRESCALE interval before the first step.

Verification
REQ-033 Reset: reset=0 for 2 cycles with enable=1 and load=1 -> out=0, tc=0, ovf=0.
REQ-034 Wrap (WIDTH=8, PRESCALE=1, up): 256 enabled cycles from 0 -> out steps 1..255 then 0; single tc pulse on the 255->0 edge; ovf=1 thereafter.
REQ-035 Prescale (PRESCALE=4): 12 enabled cycles -> out=3; enable low for 2 cycles at pre_cnt=2 -> out and pre_cnt held; the step completes on the second enabled cycle after resume.
REQ-036 Load/clear (MAX_VAL=150): load_val=200 -> out=150; load=1 together with clear=1 -> out=0, ovf=0.
REQ-037 Saturate down (SATURATE=1): load 2 then 4 steps -> out 1,0,0,0; tc pulses after the 3rd and 4th steps; ovf=1 sticky.
REQ-038 Mid-count reset: out=0x37, pre_cnt=2, reset=0 for one edge -> all zero; the next step occurs after PRESCALE enabled cycles, giving out=1.
